next_hop_client: RTL and testbench
==================================

# next_hop_client

Requester-side controller for the 8 KB, 32-bit next-hop table RAM. Accepts next-hop lookups from the forwarding pipeline and table updates from the control plane over valid/ready channels. Arbitrates them onto the single RAM port, absorbs the RAM's one-cycle read latency, and returns tagged lookup results through a small response FIFO with backpressure. Sits between the route-lookup stage and the next-hop RAM in each core.

## Interface
Parameters:
- TAG_W, 4, width of lookup tag carried from request to response
- RSP_DEPTH, 2, response FIFO entries (min 2; 2 sustains 1 lookup/cycle)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- lkp_valid  in  1  lookup request valid
- lkp_ready  out  1  lookup accepted this cycle when valid&ready
- lkp_index  in  11  word index (RAM byte address [12:2])
- lkp_tag  in  TAG_W  opaque tag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  32  next-hop word
- rsp_tag  out  TAG_W  tag of the originating lookup
- upd_valid  in  1  update request valid
- upd_ready  out  1  update accepted when valid&ready
- upd_index  in  11  word index
- upd_data  in  32  write data
- upd_be  in  4  byte enables; bit i writes data[8i+7:8i]
- ram_addr  out  11  RAM word address
- ram_wdata  out  32  RAM write data
- ram_we  out  4  RAM byte write enables
- ram_en  out  1  RAM read enable
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en
- stat_lkp_cnt  out  16  accepted-lookup count (see Configuration)
- stat_upd_cnt  out  16  accepted-update count (see Configuration)

## Operation
- One RAM operation per cycle. Grant is combinational: lkp_ready, upd_ready, ram_* are functions of the current valids, the credit state and last_grant.
- Lookup eligible iff lkp_valid and credit available. Credit: occ + inflight < RSP_DEPTH, or occ + inflight == RSP_DEPTH with a FIFO pop (rsp_valid&rsp_ready) this cycle.
- Updates are never credit-gated. They are eligible whenever upd_valid is high.
- Arbitration when both are eligible: alternate, using the last_grant register (0 = lookup, 1 = update, reset 0). An update wins when last_grant=0; a lookup wins when last_grant=1. last_grant updates only on an actual grant.
- Lookup grant: ram_en=1, ram_we=0, ram_addr=lkp_index. Set inflight=1 and latch lkp_tag.
- Update grant: ram_en=0, ram_we=upd_be, ram_addr=upd_index, ram_wdata=upd_data. upd_be=0 is accepted and writes nothing.
- No grant: ram_en=0, ram_we=0. ram_addr and ram_wdata hold their last value.
- Capture: in the cycle after a lookup grant, push {ram_rdata, latched tag} into the FIFO. This push never fails, because credit was reserved at grant time.
- FIFO: circular, RSP_DEPTH entries, occ counter of width clog2(RSP_DEPTH+1). Read and write pointers wrap modulo RSP_DEPTH. A simultaneous push and pop leaves occ unchanged.
- Ordering: responses are returned in lookup-acceptance order. An update granted in cycle N is visible to any lookup granted in N+1 or later.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_tag=0, occ=0, inflight=0, last_grant=0, stat counters=0. While reset=1: lkp_ready=0, upd_ready=0, ram_en=0, ram_we=0.
- Reset mid-operation drops any in-flight lookup and flushes the FIFO. No response is emitted for requests accepted before reset.
- Lookup latency: accepted in cycle N, rsp_valid first asserted in cycle N+2 (FIFO empty case).
- rsp_valid, rsp_data and rsp_tag are driven from the FIFO head register. They are stable while rsp_valid=1 and rsp_ready=0.
- Throughput: 1 lookup/cycle sustained with rsp_ready held high and no updates.
- Update: written at the clk edge that ends the grant cycle. No response is produced.

## Configuration
- NEXT_HOP_CLIENT_STATS_EN defined:
  - stat_lkp_cnt increments on each lookup acceptance and stat_upd_cnt on each update acceptance.
  - Both are 16-bit, saturate at 0xFFFF and clear on reset.
- Not defined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Single lookup to index 0x005 (RAM word = 0xC0A80101), tag 0x3, rsp_ready=1: rsp_valid asserts exactly 2 cycles after acceptance, with rsp_data=0xC0A80101 and rsp_tag=0x3.
- 8 back-to-back lookups to indices 0..7 with rsp_ready=1: 8 responses on 8 consecutive cycles, in order, with tags matching.
- rsp_ready=0 with lkp_valid held high: exactly 2 lookups are accepted, then lkp_ready=0. Raise rsp_ready: the two responses drain in order and acceptance resumes on the pop cycle.
- Update to index 0x010 with data 0xAABBCCDD and be=4'b0101, then a lookup to 0x010 on the next cycle: rsp_data=prior word with bytes 0 and 2 replaced by 0xDD and 0xBB.
- lkp_valid and upd_valid held high together for 6 cycles: grants alternate U,L,U,L,U,L starting from reset.
- Assert reset for 1 cycle with 1 lookup in flight and 1 response queued: rsp_valid=0 next cycle and no stale response appears afterwards. With NEXT_HOP_CLIENT_STATS_EN defined, both counters read 0.

Source files
------------

// File: rtl/next_hop_client.sv
// Next-hop RAM requester: arbitrates lookups and updates onto one RAM port and returns
// tagged lookup results through a credit-reserved response FIFO. Optional counters: NEXT_HOP_CLIENT_STATS_EN.
module next_hop_client #(
   parameter int TAG_W     = 4,
   parameter int RSP_DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lkp_valid,
   output logic             lkp_ready,
   input  logic [10:0]      lkp_index,
   input  logic [TAG_W-1:0] lkp_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   input  logic             upd_valid,
   output logic             upd_ready,
   input  logic [10:0]      upd_index,
   input  logic [31:0]      upd_data,
   input  logic [3:0]       upd_be,
   output logic [10:0]      ram_addr,
   output logic [31:0]      ram_wdata,
   output logic [3:0]       ram_we,
   output logic             ram_en,
   input  logic [31:0]      ram_rdata,
   output logic [15:0]      stat_lkp_cnt,
   output logic [15:0]      stat_upd_cnt
);
   localparam int OCC_W = $clog2(RSP_DEPTH + 1);
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int SUM_W = OCC_W + 1;

   logic [OCC_W-1:0] occ_q, occ_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic             inflight_q, inflight_d;
   logic             last_grant_q, last_grant_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [10:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      fifo_data_q [RSP_DEPTH];
   logic [31:0]      fifo_data_d [RSP_DEPTH];
   logic [TAG_W-1:0] fifo_tag_q [RSP_DEPTH];
   logic [TAG_W-1:0] fifo_tag_d [RSP_DEPTH];

   logic [SUM_W-1:0] sum_s;
   logic             pop_s, push_s, credit_s;
   logic             lkp_elig_s, upd_elig_s, grant_lkp_s, grant_upd_s;

   // Credit check and alternating arbitration between lookups and updates
   always_comb begin
      sum_s       = SUM_W'(occ_q) + SUM_W'(inflight_q);
      pop_s       = (occ_q != {OCC_W{1'b0}}) && rsp_ready;
      push_s      = inflight_q;
      credit_s    = (sum_s < SUM_W'(RSP_DEPTH)) || ((sum_s == SUM_W'(RSP_DEPTH)) && pop_s);
      lkp_elig_s  = lkp_valid && credit_s && !reset;
      upd_elig_s  = upd_valid && !reset;
      grant_lkp_s = lkp_elig_s && (!upd_elig_s || last_grant_q);
      grant_upd_s = upd_elig_s && (!lkp_elig_s || !last_grant_q);
   end

   // RAM port drive; address and write data hold their last value when idle
   always_comb begin
      lkp_ready = grant_lkp_s;
      upd_ready = grant_upd_s;
      ram_en    = grant_lkp_s;
      if (grant_upd_s) begin
         ram_we = upd_be;
      end else begin
         ram_we = 4'b0000;
      end
      if (grant_lkp_s) begin
         ram_addr = lkp_index;
      end else if (grant_upd_s) begin
         ram_addr = upd_index;
      end else begin
         ram_addr = addr_q;
      end
      if (grant_upd_s) begin
         ram_wdata = upd_data;
      end else begin
         ram_wdata = wdata_q;
      end
   end

   // Next-state: FIFO pointers/occupancy, in-flight capture and grant history
   always_comb begin
      addr_d      = ram_addr;
      wdata_d     = ram_wdata;
      inflight_d  = grant_lkp_s;
      fifo_data_d = fifo_data_q;
      fifo_tag_d  = fifo_tag_q;
      if (grant_lkp_s) begin
         tag_d = lkp_tag;
      end else begin
         tag_d = tag_q;
      end
      if (grant_lkp_s) begin
         last_grant_d = 1'b0;
      end else if (grant_upd_s) begin
         last_grant_d = 1'b1;
      end else begin
         last_grant_d = last_grant_q;
      end
      case ({push_s, pop_s})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
      if (push_s) begin
         fifo_data_d[wr_ptr_q] = ram_rdata;
         fifo_tag_d[wr_ptr_q]  = tag_q;
         wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // State registers; reset drops the in-flight lookup and flushes the FIFO
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q        <= {OCC_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         wr_ptr_q     <= {PTR_W{1'b0}};
         inflight_q   <= 1'b0;
         last_grant_q <= 1'b0;
         tag_q        <= {TAG_W{1'b0}};
         addr_q       <= 11'h000;
         wdata_q      <= 32'h0000_0000;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_data_q[i] <= 32'h0000_0000;
            fifo_tag_q[i]  <= {TAG_W{1'b0}};
         end
      end else begin
         occ_q        <= occ_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         inflight_q   <= inflight_d;
         last_grant_q <= last_grant_d;
         tag_q        <= tag_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         fifo_data_q  <= fifo_data_d;
         fifo_tag_q   <= fifo_tag_d;
      end
   end

   // Response side comes straight from the FIFO head entry
   always_comb begin
      rsp_valid = (occ_q != {OCC_W{1'b0}});
      rsp_data  = fifo_data_q[rd_ptr_q];
      rsp_tag   = fifo_tag_q[rd_ptr_q];
   end

`ifdef NEXT_HOP_CLIENT_STATS_EN
   logic [15:0] stat_lkp_q, stat_lkp_d, stat_upd_q, stat_upd_d;

   // Saturating acceptance counters
   always_comb begin
      if (grant_lkp_s && (stat_lkp_q != 16'hFFFF)) begin
         stat_lkp_d = stat_lkp_q + 16'd1;
      end else begin
         stat_lkp_d = stat_lkp_q;
      end
      if (grant_upd_s && (stat_upd_q != 16'hFFFF)) begin
         stat_upd_d = stat_upd_q + 16'd1;
      end else begin
         stat_upd_d = stat_upd_q;
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_lkp_q <= 16'h0000;
         stat_upd_q <= 16'h0000;
      end else begin
         stat_lkp_q <= stat_lkp_d;
         stat_upd_q <= stat_upd_d;
      end
   end

   assign stat_lkp_cnt = stat_lkp_q;
   assign stat_upd_cnt = stat_upd_q;
`else
   assign stat_lkp_cnt = 16'h0000;
   assign stat_upd_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_next_hop_client.sv
// Scoreboard bench for next_hop_client with a behavioural one-cycle-latency RAM.
module tb_next_hop_client;
   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        lkp_valid, lkp_ready;
   logic [10:0] lkp_index;
   logic [3:0]  lkp_tag;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_tag;
   logic        upd_valid, upd_ready;
   logic [10:0] upd_index;
   logic [31:0] upd_data;
   logic [3:0]  upd_be;
   logic [10:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_we;
   logic        ram_en;
   logic [31:0] ram_rdata;
   logic [15:0] stat_lkp_cnt, stat_upd_cnt;

   logic [31:0] ram_mem [2048];
   logic        ram_init = 1'b0;
   logic [31:0] lkp_exp;
   exp_t        exp_q[$];
   int          pop_cyc[$];
   int          cyc;
   int          total;
   int          bad;

   always #5 clk = ~clk;

   next_hop_client #(.TAG_W(4), .RSP_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_index(lkp_index), .lkp_tag(lkp_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_data(upd_data),
      .upd_be(upd_be),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_en(ram_en),
      .ram_rdata(ram_rdata),
      .stat_lkp_cnt(stat_lkp_cnt), .stat_upd_cnt(stat_upd_cnt)
   );

   // RAM model: word k holds 0xA5A5_0000+k, except word 5 = 0xC0A80101
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 2048; i++) ram_mem[i] <= 32'hA5A5_0000 + 32'(i);
         ram_mem[5] <= 32'hC0A8_0101;
         ram_init   <= 1'b1;
      end else begin
         if (ram_en) ram_rdata <= ram_mem[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: records accepted lookups and checks every popped response in order
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            exp_q.delete();
         end else begin
            if (rsp_valid && rsp_ready) begin
               pop_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rsp_unexpected: got data=%h tag=%h want no response", rsp_data, rsp_tag);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_data", 64'(rsp_data), 64'(e.data));
                  chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
               end
            end
            if (lkp_valid && lkp_ready) exp_q.push_back({lkp_exp, lkp_tag});
         end
      end
   endtask

   // Called at #1 after a posedge; returns at #1 after the posedge that accepts it
   task automatic do_lkp(input logic [10:0] idx, input logic [3:0] tag, input logic [31:0] exp,
                         output int waits);
      lkp_valid = 1'b1;
      lkp_index = idx;
      lkp_tag   = tag;
      lkp_exp   = exp;
      waits     = 0;
      @(negedge clk);
      while (!lkp_ready && waits < 50) begin
         @(posedge clk); #1;
         waits++;
         @(negedge clk);
      end
      if (!lkp_ready) chk("lkp_timeout", 64'(lkp_ready), 64'(1));
      @(posedge clk); #1;
   endtask

   task automatic do_upd(input logic [10:0] idx, input logic [31:0] data, input logic [3:0] be);
      int waits = 0;
      upd_valid = 1'b1;
      upd_index = idx;
      upd_data  = data;
      upd_be    = be;
      @(negedge clk);
      while (!upd_ready && waits < 50) begin
         @(posedge clk); #1;
         waits++;
         @(negedge clk);
      end
      chk("upd_accept", 64'(upd_ready), 64'(1));
      chk("upd_ram_we", 64'(ram_we), 64'(be));
      chk("upd_ram_addr", 64'(ram_addr), 64'(idx));
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      chk("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      int          w;
      int          wsum;
      int          acc;
      logic [5:0]  arb_pat;
      logic [31:0] exp8 [8];
      total = 0; bad = 0; cyc = 0;
      reset = 1'b1; rsp_ready = 1'b1;
      lkp_valid = 1'b1; lkp_index = 11'h000; lkp_tag = 4'h0; lkp_exp = 32'h0;
      upd_valid = 1'b1; upd_index = 11'h000; upd_data = 32'h0; upd_be = 4'hF;
      fork monitor(); join_none

      // reset state with both requesters asserting
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_lkp_ready", 64'(lkp_ready), 64'(0));
      chk("rst_upd_ready", 64'(upd_ready), 64'(0));
      chk("rst_ram_en", 64'(ram_en), 64'(0));
      chk("rst_ram_we", 64'(ram_we), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));
      chk("rst_stat_lkp", 64'(stat_lkp_cnt), 64'(0));
      @(posedge clk); #1;
      lkp_valid = 1'b0; upd_valid = 1'b0; reset = 1'b0;
      @(posedge clk); #1;

      // single lookup, two-cycle latency
      do_lkp(11'h005, 4'h3, 32'hC0A8_0101, w);
      lkp_valid = 1'b0;
      @(negedge clk);
      chk("lat_n1_rsp_valid", 64'(rsp_valid), 64'(0));
      @(negedge clk);
      chk("lat_n2_rsp_valid", 64'(rsp_valid), 64'(1));
      drain();

      // eight back-to-back lookups
      exp8[0] = 32'hA5A5_0000; exp8[1] = 32'hA5A5_0001; exp8[2] = 32'hA5A5_0002;
      exp8[3] = 32'hA5A5_0003; exp8[4] = 32'hA5A5_0004; exp8[5] = 32'hC0A8_0101;
      exp8[6] = 32'hA5A5_0006; exp8[7] = 32'hA5A5_0007;
      pop_cyc.delete();
      wsum = 0;
      for (int i = 0; i < 8; i++) begin
         do_lkp(11'(i), 4'(i), exp8[i], w);
         wsum += w;
      end
      lkp_valid = 1'b0;
      drain();
      chk("b2b_no_stall", 64'(wsum), 64'(0));
      chk("b2b_rsp_count", 64'(pop_cyc.size()), 64'(8));
      if (pop_cyc.size() == 8) chk("b2b_consecutive", 64'(pop_cyc[7] - pop_cyc[0]), 64'(7));

      // backpressure: only two lookups fit, resume on the pop cycle
      rsp_ready = 1'b0;
      acc = 0;
      lkp_valid = 1'b1; lkp_index = 11'h020; lkp_tag = 4'h8; lkp_exp = 32'hA5A5_0020;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (lkp_ready) acc++;
         @(posedge clk); #1;
         lkp_index = 11'h020 + 11'(acc);
         lkp_tag   = 4'h8 + 4'(acc);
         lkp_exp   = 32'hA5A5_0020 + 32'(acc);
      end
      chk("bp_accepts", 64'(acc), 64'(2));
      @(negedge clk);
      chk("bp_ready_low", 64'(lkp_ready), 64'(0));
      chk("bp_head_tag", 64'(rsp_tag), 64'(4'h8));
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_resume_on_pop", 64'(lkp_ready), 64'(1));
      @(posedge clk); #1;
      lkp_valid = 1'b0;
      drain();

      // partial-byte update then lookup the next cycle
      do_upd(11'h010, 32'hAABB_CCDD, 4'b0101);
      upd_valid = 1'b0;
      do_lkp(11'h010, 4'h5, 32'hA5BB_00DD, w);
      lkp_valid = 1'b0;
      drain();

      // alternating arbitration from reset: U,L,U,L,U,L
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      arb_pat = 6'b010101;
      lkp_valid = 1'b1; lkp_index = 11'h007; lkp_tag = 4'h7; lkp_exp = 32'hA5A5_0007;
      upd_valid = 1'b1; upd_index = 11'h100; upd_data = 32'h1234_5678; upd_be = 4'hF;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("arb_upd_ready", 64'(upd_ready), 64'(arb_pat[c]));
         chk("arb_lkp_ready", 64'(lkp_ready), 64'(!arb_pat[c]));
         chk("arb_ram_en", 64'(ram_en), 64'(!arb_pat[c]));
         @(posedge clk); #1;
      end
      lkp_valid = 1'b0; upd_valid = 1'b0;
      drain();
`ifdef NEXT_HOP_CLIENT_STATS_EN
      chk("stat_lkp_after_arb", 64'(stat_lkp_cnt), 64'(3));
      chk("stat_upd_after_arb", 64'(stat_upd_cnt), 64'(3));
`else
      chk("stat_lkp_tied", 64'(stat_lkp_cnt), 64'(0));
      chk("stat_upd_tied", 64'(stat_upd_cnt), 64'(0));
`endif

      // reset with one response queued and one lookup in flight
      rsp_ready = 1'b0;
      do_lkp(11'h001, 4'h1, 32'hA5A5_0001, w);
      do_lkp(11'h002, 4'h2, 32'hA5A5_0002, w);
      lkp_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("pre_rst_queued", 64'(rsp_valid), 64'(1));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("post_rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("post_rst_stat_lkp", 64'(stat_lkp_cnt), 64'(0));
      chk("post_rst_stat_upd", 64'(stat_upd_cnt), 64'(0));
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post_rst_no_stale", 64'(rsp_valid), 64'(0));
      end
      chk("post_rst_sb_empty", 64'(exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
